// File: rtl/register_file_sb.sv
// rtl/register_file_sb.sv - Register file with two combinational read ports, one write port and a per-register scoreboard
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   read1/read2, readN_en      read addresses and operand-used qualifiers
//   read_out1/read_out2        combinational read data (optionally forwarded from the write port)
//   write_reg/write_data       write address/data, committed on posedge when reg_write=1
//   mark_valid/mark_reg        decode marks a new outstanding write to mark_reg
//   read1_busy/read2_busy      addressed register still has an unresolved producer
//   stall                      decode must hold this cycle
//   any_pending                at least one outstanding-write counter is nonzero
//   sb_overflow                sticky: a mark arrived while its counter was saturated
module register_file_sb #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_REGS   = 4,
    parameter int ADDR_WIDTH = 2,
    parameter int CNT_WIDTH  = 2,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read1,
    input  logic [ADDR_WIDTH-1:0] read2,
    input  logic                  read1_en,
    input  logic                  read2_en,
    output logic [DATA_WIDTH-1:0] read_out1,
    output logic [DATA_WIDTH-1:0] read_out2,
    input  logic [ADDR_WIDTH-1:0] write_reg,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    input  logic                  mark_valid,
    input  logic [ADDR_WIDTH-1:0] mark_reg,
    output logic                  read1_busy,
    output logic                  read2_busy,
    output logic                  stall,
    output logic                  any_pending,
    output logic                  sb_overflow
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [DATA_WIDTH-1:0] rf_q  [NUM_REGS];
    logic [DATA_WIDTH-1:0] rf_d  [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt_q [NUM_REGS];
    logic [CNT_WIDTH-1:0]  cnt_d [NUM_REGS];
    logic                  sb_overflow_q;
    logic                  sb_overflow_d;

    logic [NUM_REGS-1:0]   inc;
    logic [NUM_REGS-1:0]   dec;
    logic                  wr_hit1;
    logic                  wr_hit2;

    // Per-register increment/decrement requests. A write to a register with
    // no outstanding producer is an unscheduled write and leaves the count alone.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i] = mark_valid && (mark_reg == ADDR_WIDTH'(i));
            dec[i] = reg_write && (write_reg == ADDR_WIDTH'(i)) && (cnt_q[i] != '0);
        end
    end

    always_comb begin
        rf_d          = rf_q;
        cnt_d         = cnt_q;
        sb_overflow_d = sb_overflow_q;
        if (reg_write) begin
            rf_d[write_reg] = write_data;
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            if (inc[i] && !dec[i]) begin
                // Saturate rather than wrap; losing track of a producer is flagged.
                if (cnt_q[i] == CNT_MAX) begin
                    sb_overflow_d = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_ONE;
                end
            end else if (dec[i] && !inc[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i]  <= '0;
                cnt_q[i] <= '0;
            end
            sb_overflow_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                rf_q[i]  <= rf_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            sb_overflow_q <= sb_overflow_d;
        end
    end

    assign wr_hit1 = reg_write && (write_reg == read1);
    assign wr_hit2 = reg_write && (write_reg == read2);

    assign read_out1 = ((BYPASS != 0) && wr_hit1) ? write_data : rf_q[read1];
    assign read_out2 = ((BYPASS != 0) && wr_hit2) ? write_data : rf_q[read2];

    // When the last outstanding producer is being written this cycle and is
    // forwarded, the operand is ready. With two or more outstanding, a younger
    // producer is still in flight, so the register stays busy.
    assign read1_busy = (cnt_q[read1] != '0) &&
                        !((BYPASS != 0) && wr_hit1 && (cnt_q[read1] == CNT_ONE));
    assign read2_busy = (cnt_q[read2] != '0) &&
                        !((BYPASS != 0) && wr_hit2 && (cnt_q[read2] == CNT_ONE));

    assign stall = (read1_en && read1_busy) || (read2_en && read2_busy);

    always_comb begin
        any_pending = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            any_pending = any_pending || (cnt_q[i] != '0);
        end
    end

    assign sb_overflow = sb_overflow_q;

endmodule

// File: tb/tb_register_file_sb.sv
// tb/tb_register_file_sb.sv - Directed self-checking bench for register_file_sb
module tb_register_file_sb;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  read1, read2, write_reg, mark_reg;
    logic        read1_en, read2_en, reg_write, mark_valid;
    logic [15:0] write_data;

    logic [15:0] read_out1, read_out2, nb_read_out1, nb_read_out2;
    logic        read1_busy, read2_busy, stall, any_pending, sb_overflow;
    logic        nb_read1_busy, nb_read2_busy, nb_stall, nb_any_pending, nb_sb_overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    register_file_sb #(.BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .read1(read1), .read2(read2), .read1_en(read1_en), .read2_en(read2_en),
        .read_out1(read_out1), .read_out2(read_out2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .mark_valid(mark_valid), .mark_reg(mark_reg),
        .read1_busy(read1_busy), .read2_busy(read2_busy), .stall(stall),
        .any_pending(any_pending), .sb_overflow(sb_overflow)
    );

    register_file_sb #(.BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n),
        .read1(read1), .read2(read2), .read1_en(read1_en), .read2_en(read2_en),
        .read_out1(nb_read_out1), .read_out2(nb_read_out2),
        .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
        .mark_valid(mark_valid), .mark_reg(mark_reg),
        .read1_busy(nb_read1_busy), .read2_busy(nb_read2_busy), .stall(nb_stall),
        .any_pending(nb_any_pending), .sb_overflow(nb_sb_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance through one posedge, then settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reg_write  = 1'b0;
        mark_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0;
        read1 = 2'd0; read2 = 2'd0; read1_en = 1'b0; read2_en = 1'b0;
        write_reg = 2'd0; write_data = 16'h0; reg_write = 1'b0;
        mark_valid = 1'b0; mark_reg = 2'd0;

        // Reset state
        tick();
        tick();
        check("rst_out1", read_out1, 0);
        check("rst_out2", read_out2, 0);
        check("rst_busy1", read1_busy, 0);
        check("rst_busy2", read2_busy, 0);
        check("rst_stall", stall, 0);
        check("rst_pending", any_pending, 0);
        check("rst_ovf", sb_overflow, 0);

        reset_n = 1'b1;
        tick();

        // Write/read with and without bypass
        reg_write = 1'b1; write_reg = 2'd2; write_data = 16'h1234; read1 = 2'd2;
        #1;
        check("byp_same_cycle", read_out1, 16'h1234);
        check("nobyp_old_value", nb_read_out1, 16'h0000);
        tick();
        idle();
        #1;
        check("byp_after_edge", read_out1, 16'h1234);
        check("nobyp_after_edge", nb_read_out1, 16'h1234);

        // Hazard on reg 1; a same-cycle mark does not make it busy yet
        mark_valid = 1'b1; mark_reg = 2'd1; read1 = 2'd1; read1_en = 1'b1;
        #1;
        check("mark_same_cycle_busy", read1_busy, 0);
        check("mark_same_cycle_stall", stall, 0);
        tick();
        idle();
        #1;
        check("hazard_busy", read1_busy, 1);
        check("hazard_stall", stall, 1);
        check("hazard_pending", any_pending, 1);
        read1_en = 1'b0;
        #1;
        check("hazard_no_en_stall", stall, 0);
        read1_en = 1'b1;
        reg_write = 1'b1; write_reg = 2'd1; write_data = 16'h00AA;
        #1;
        check("resolve_busy", read1_busy, 0);
        check("resolve_stall", stall, 0);
        check("resolve_fwd", read_out1, 16'h00AA);
        check("nobyp_resolve_busy", nb_read1_busy, 1);
        check("nobyp_resolve_stall", nb_stall, 1);
        tick();
        idle();
        #1;
        check("resolved_busy", read1_busy, 0);
        check("resolved_pending", any_pending, 0);
        read1_en = 1'b0;

        // WAW on reg 3
        read2 = 2'd3; read2_en = 1'b1;
        mark_valid = 1'b1; mark_reg = 2'd3;
        tick();
        tick();
        idle();
        #1;
        check("waw_busy_cnt2", read2_busy, 1);
        reg_write = 1'b1; write_reg = 2'd3; write_data = 16'h3333;
        #1;
        check("waw_first_write_busy", read2_busy, 1);
        check("waw_first_write_stall", stall, 1);
        tick();
        idle();
        #1;
        check("waw_cnt1_busy", read2_busy, 1);
        check("waw_cnt1_data", read_out2, 16'h3333);
        reg_write = 1'b1; write_reg = 2'd3; write_data = 16'h4444;
        #1;
        check("waw_second_write_busy", read2_busy, 0);
        check("waw_second_write_stall", stall, 0);
        tick();
        idle();
        #1;
        check("waw_pending", any_pending, 0);
        check("waw_data", read_out2, 16'h4444);
        read2_en = 1'b0;

        // Simultaneous mark and write to reg 0 holding cnt=1
        read1 = 2'd0;
        mark_valid = 1'b1; mark_reg = 2'd0;
        tick();
        mark_valid = 1'b1; mark_reg = 2'd0;
        reg_write = 1'b1; write_reg = 2'd0; write_data = 16'h0F0F;
        tick();
        idle();
        #1;
        check("mark_write_busy", read1_busy, 1);
        check("mark_write_pending", any_pending, 1);
        check("mark_write_data", read_out1, 16'h0F0F);
        reg_write = 1'b1; write_reg = 2'd0; write_data = 16'h0F0F;
        tick();
        idle();
        #1;
        check("reg0_cleared", any_pending, 0);

        // Unscheduled write to reg 2
        reg_write = 1'b1; write_reg = 2'd2; write_data = 16'h5555;
        tick();
        idle();
        read1 = 2'd2;
        #1;
        check("unsched_data", read_out1, 16'h5555);
        check("unsched_busy", read1_busy, 0);
        check("unsched_pending", any_pending, 0);
        check("unsched_ovf", sb_overflow, 0);

        // Overflow on reg 1
        read2 = 2'd1;
        mark_valid = 1'b1; mark_reg = 2'd1;
        tick();
        tick();
        tick();
        #1;
        check("ovf_not_yet", sb_overflow, 0);
        tick();
        idle();
        #1;
        check("ovf_set", sb_overflow, 1);
        for (int k = 0; k < 3; k++) begin
            reg_write = 1'b1; write_reg = 2'd1; write_data = 16'h0100 + 16'(k);
            tick();
        end
        idle();
        #1;
        check("ovf_drained_pending", any_pending, 0);
        check("ovf_sticky", sb_overflow, 1);
        check("ovf_last_data", read_out2, 16'h0102);

        // Asynchronous reset mid-cycle with pending state
        mark_valid = 1'b1; mark_reg = 2'd2;
        tick();
        idle();
        #1;
        check("pre_areset_busy", read1_busy, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("areset_out1", read_out1, 0);
        check("areset_out2", read_out2, 0);
        check("areset_busy", read1_busy, 0);
        check("areset_pending", any_pending, 0);
        check("areset_ovf", sb_overflow, 0);
        check("areset_nb_out1", nb_read_out1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
